// File: rtl/sipo_frame_ctrl.sv
// Start/stop-framed serial sequencer driving an external WIDTH-bit SIPO, with a valid/ready output stage.
// Optional even-parity bit and par_err output when SIPO_PARITY_EN is defined.
`timescale 1ns/1ps
module sipo_frame_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned BIT_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic [WIDTH-1:0] sipo_q,
    output logic             sipo_shift,
    output logic             sipo_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun,
`ifdef SIPO_PARITY_EN
    output logic             par_err,
`endif
    input  logic             err_clr
);

    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DW = $clog2(BIT_DIV) + 1;
    localparam logic [DW-1:0] HALF     = DW'(BIT_DIV / 2);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef SIPO_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_next;
    logic [BW-1:0] bit_cnt;
    logic          sample;
    logic          accept;

    // The detect cycle is divider count 0 of the start bit, so every bit is sampled at count HALF.
    assign sample   = (div_cnt == HALF);
    assign div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    assign accept   = out_valid && out_ready;

    // Strobes are decoded so the SIPO shifts on the same edge that samples each data bit.
    assign sipo_shift = !rst && (state == DATA) && sample;
    assign sipo_clr   = !rst && (state == IDLE) && !din;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SIPO_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            if (accept)
                out_valid <= 1'b0;
            if (err_clr) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
`ifdef SIPO_PARITY_EN
                par_err   <= 1'b0;
`endif
            end
            div_cnt <= div_next;

            case (state)
                IDLE: begin
                    if (!din) begin
                        bit_cnt <= '0;
                        // With BIT_DIV=1 the detect cycle is already the start-bit sample point.
                        state   <= (HALF == '0) ? DATA : START;
                    end else begin
                        div_cnt <= '0;
                    end
                end
                START: begin
                    if (sample) begin
                        if (din) begin
                            state   <= IDLE;
                            div_cnt <= '0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (sample) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef SIPO_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef SIPO_PARITY_EN
                PARITY: begin
                    if (sample) begin
                        if ((^sipo_q) != din)
                            par_err <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (sample) begin
                        state   <= IDLE;
                        div_cnt <= '0;
                        if (!din) begin
                            frame_err <= 1'b1;
                        end else if (out_valid && !out_ready) begin
                            overrun <= 1'b1;
                        end else begin
                            out_data  <= sipo_q;
                            out_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    div_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl: one instance at BIT_DIV=1, one at BIT_DIV=4, each with a SIPO model.
// Parity frames are exercised when SIPO_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_sipo_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, err_clr;
    logic       din, out_ready;
    logic [7:0] sipo_q, out_data;
    logic       sipo_shift, sipo_clr, out_valid, frame_err, overrun;
    logic       din4, out_ready4;
    logic [7:0] sipo_q4, out_data4;
    logic       sipo_shift4, sipo_clr4, out_valid4, frame_err4, overrun4;
`ifdef SIPO_PARITY_EN
    logic       par_err, par_err4;
`endif

    int          ncmp = 0;
    int          nfail = 0;
    logic [15:0] shm, clm;
    int          pidx;
    int          nsh4;

    sipo_frame_ctrl #(.WIDTH(8), .BIT_DIV(1)) dut (
        .clk(clk), .rst(rst), .din(din), .sipo_q(sipo_q),
        .sipo_shift(sipo_shift), .sipo_clr(sipo_clr),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_err(frame_err), .overrun(overrun),
`ifdef SIPO_PARITY_EN
        .par_err(par_err),
`endif
        .err_clr(err_clr)
    );

    sipo_frame_ctrl #(.WIDTH(8), .BIT_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .din(din4), .sipo_q(sipo_q4),
        .sipo_shift(sipo_shift4), .sipo_clr(sipo_clr4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
        .frame_err(frame_err4), .overrun(overrun4),
`ifdef SIPO_PARITY_EN
        .par_err(par_err4),
`endif
        .err_clr(err_clr)
    );

    // External LSB-first SIPOs: serial line enters at the MSB end
    always_ff @(posedge clk) begin
        if (rst || sipo_clr)  sipo_q <= '0;
        else if (sipo_shift)  sipo_q <= {din, sipo_q[7:1]};
        if (rst || sipo_clr4) sipo_q4 <= '0;
        else if (sipo_shift4) sipo_q4 <= {din4, sipo_q4[7:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One serial bit period on the BIT_DIV=1 line, logging strobes by period index
    task automatic bitp(input logic b);
        din = b;
        #1;
        if (sipo_shift) shm[pidx] = 1'b1;
        if (sipo_clr)   clm[pidx] = 1'b1;
        pidx++;
        @(posedge clk);
        #1;
    endtask

    task automatic bitp4(input logic b);
        din4 = b;
        #1;
        if (sipo_shift4) nsh4++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stopb, input logic rdy);
        logic keep;
        shm  = '0;
        clm  = '0;
        pidx = 0;
        bitp(1'b0);
        for (int i = 0; i < 8; i++) bitp(d[i]);
`ifdef SIPO_PARITY_EN
        bitp(par);
`endif
        keep      = out_ready;
        out_ready = keep | rdy;
        bitp(stopb);
        out_ready = keep;
        din       = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d4;
        rst = 1'b1; err_clr = 1'b0; din = 1'b1; out_ready = 1'b0;
        din4 = 1'b1; out_ready4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_shift", sipo_shift, 0);
        chk("rst_clr", sipo_clr, 0);
        rst = 1'b0;
        tick();

        // Clean frame 0x5A, consumer ready
        out_ready = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        chk("t1_shift_mask", shm, 16'h01FE);
        chk("t1_clr_mask", clm, 16'h0001);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 8'h5A);
        chk("t1_ferr", frame_err, 0);
        tick();
        chk("t1_valid_drop", out_valid, 0);

        // Bad stop bit
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
        chk("t2_valid", out_valid, 0);
        chk("t2_ferr", frame_err, 1);
        chk("t2_data_held", out_data, 8'h5A);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t2_ferr_clr", frame_err, 0);

        // err_clr coincident with a new frame error: error wins
        err_clr = 1'b1;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        err_clr = 1'b0;
        chk("t2b_set_wins", frame_err, 1);
        tick();
        chk("t2b_sticky", frame_err, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t2b_clr", frame_err, 0);

        // Back-to-back frames with consumer stalled
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        chk("t3_valid1", out_valid, 1);
        chk("t3_data1", out_data, 8'h11);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        chk("t3_data_kept", out_data, 8'h11);
        chk("t3_valid_kept", out_valid, 1);
        chk("t3_overrun", overrun, 1);
        out_ready = 1'b1; tick();
        chk("t3_accepted", out_valid, 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t3_ovr_clr", overrun, 0);

        // Acceptance and new-word load on the same edge
        out_ready = 1'b0;
        send_frame(8'h33, 1'b0, 1'b1, 1'b0);
        chk("sim_data1", out_data, 8'h33);
        send_frame(8'h44, 1'b0, 1'b1, 1'b1);
        chk("sim_valid", out_valid, 1);
        chk("sim_data2", out_data, 8'h44);
        chk("sim_no_ovr", overrun, 0);
        out_ready = 1'b1; tick();
        chk("sim_drop", out_valid, 0);

        // Reset after the third shift pulse, then a clean frame 0x96
        shm = '0; clm = '0; pidx = 0;
        bitp(1'b0); bitp(1'b0); bitp(1'b1); bitp(1'b1);
        chk("t5_three_shifts", shm, 16'h000E);
        rst = 1'b1;
        bitp(1'b0);
        chk("t5_valid", out_valid, 0);
        chk("t5_data", out_data, 0);
        chk("t5_ferr", frame_err, 0);
        chk("t5_ovr", overrun, 0);
        rst = 1'b0; din = 1'b1; #1;
        chk("t5_idle_shift", sipo_shift, 0);
        tick();
        send_frame(8'h96, 1'b0, 1'b1, 1'b0);
        chk("t5_shift_mask", shm, 16'h01FE);
        chk("t5_valid_new", out_valid, 1);
        chk("t5_data_new", out_data, 8'h96);
        tick();

`ifdef SIPO_PARITY_EN
        // 0x07 has odd weight, so parity bit 0 is wrong and 1 is right
        send_frame(8'h07, 1'b0, 1'b1, 1'b0);
        chk("t6_par_err", par_err, 1);
        chk("t6_data", out_data, 8'h07);
        chk("t6_valid", out_valid, 1);
        tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t6_par_clr", par_err, 0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        chk("t6_par_ok", par_err, 0);
        chk("t6_data2", out_data, 8'h07);
        tick();
`endif

        // BIT_DIV=4: one-cycle low glitch is rejected
        nsh4 = 0;
        bitp4(1'b0);
        repeat (11) bitp4(1'b1);
        chk("t4_no_shift", nsh4, 0);
        chk("t4_ferr", frame_err4, 0);
        chk("t4_ovr", overrun4, 0);
        chk("t4_valid", out_valid4, 0);

        // BIT_DIV=4: full frame 0xA5, four cycles per bit
        d4 = 8'hA5;
        nsh4 = 0;
        repeat (4) bitp4(1'b0);
        for (int i = 0; i < 8; i++) repeat (4) bitp4(d4[i]);
`ifdef SIPO_PARITY_EN
        repeat (4) bitp4(^d4);
`endif
        repeat (4) bitp4(1'b1);
        chk("t4_shift_count", nsh4, 8);
        chk("t4_frame_valid", out_valid4, 1);
        chk("t4_frame_data", out_data4, 8'hA5);
        chk("t4_frame_ferr", frame_err4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
